// File: rtl/register_universal_nbits.sv
// Parametrised universal register: load, shift, rotate, step up/down,
// with registered carry, sticky overflow and a combinational zero flag.
module register_universal_nbits #(
  parameter int               WIDTH       = 5,
  parameter int               STEP        = 1,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic             clock,
  input  logic             clear,
  input  logic             enable,
  input  logic [2:0]       mode,
  input  logic [WIDTH-1:0] register_in,
  input  logic             serial_in,
  output logic [WIDTH-1:0] out,
  output logic             carry,
  output logic             zero,
  output logic             overflow
);

  typedef enum logic [2:0] {
    M_HOLD = 3'b000,
    M_LOAD = 3'b001,
    M_SHL  = 3'b010,
    M_SHR  = 3'b011,
    M_ROL  = 3'b100,
    M_ROR  = 3'b101,
    M_INC  = 3'b110,
    M_DEC  = 3'b111
  } mode_e;

  localparam logic [WIDTH:0] STEP_W = (WIDTH+1)'(STEP);

  logic [WIDTH-1:0] out_q, out_d;
  logic             carry_q, carry_d;
  logic             ovf_q, ovf_d;
  logic [WIDTH:0]   arith;

  always_comb begin
    out_d   = out_q;
    carry_d = carry_q;
    ovf_d   = ovf_q;
    arith   = '0;
    if (enable) begin
      // X/unknown mode never matches an item and falls through to hold.
      case (mode)
        M_LOAD: begin
          out_d   = register_in;
          carry_d = 1'b0;
          ovf_d   = 1'b0;
        end
        M_SHL: begin
          out_d   = {out_q[WIDTH-2:0], serial_in};
          carry_d = out_q[WIDTH-1];
        end
        M_SHR: begin
          out_d   = {serial_in, out_q[WIDTH-1:1]};
          carry_d = out_q[0];
        end
        M_ROL: begin
          out_d   = {out_q[WIDTH-2:0], out_q[WIDTH-1]};
          carry_d = out_q[WIDTH-1];
        end
        M_ROR: begin
          out_d   = {out_q[0], out_q[WIDTH-1:1]};
          carry_d = out_q[0];
        end
        M_INC: begin
          arith   = {1'b0, out_q} + STEP_W;
          out_d   = arith[WIDTH-1:0];
          carry_d = arith[WIDTH];
          ovf_d   = ovf_q | arith[WIDTH];
        end
        M_DEC: begin
          // STEP < 2^WIDTH, so the extra MSB of the difference is exactly the borrow.
          arith   = {1'b0, out_q} - STEP_W;
          out_d   = arith[WIDTH-1:0];
          carry_d = arith[WIDTH];
          ovf_d   = ovf_q | arith[WIDTH];
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (clear) begin
      out_q   <= RESET_VALUE;
      carry_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      out_q   <= out_d;
      carry_q <= carry_d;
      ovf_q   <= ovf_d;
    end
  end

  assign out      = out_q;
  assign carry    = carry_q;
  assign overflow = ovf_q;
  assign zero     = (out_q == '0);

endmodule

// File: tb/tb_register_universal_nbits.sv
// Bench for register_universal_nbits: three configurations driven in lockstep
// and compared each cycle against an integer-arithmetic reference model.
module tb_register_universal_nbits;

  logic       clock, clear, enable, serial_in;
  logic [2:0] mode;
  logic [7:0] rin;

  logic [4:0] o0, o1;
  logic [7:0] o2;
  logic       c0, c1, c2, z0, z1, z2, v0, v1, v2;

  register_universal_nbits #(.WIDTH(5), .STEP(1), .RESET_VALUE(5'd0)) u0 (
    .clock(clock), .clear(clear), .enable(enable), .mode(mode),
    .register_in(rin[4:0]), .serial_in(serial_in),
    .out(o0), .carry(c0), .zero(z0), .overflow(v0));

  register_universal_nbits #(.WIDTH(5), .STEP(3), .RESET_VALUE(5'd0)) u1 (
    .clock(clock), .clear(clear), .enable(enable), .mode(mode),
    .register_in(rin[4:0]), .serial_in(serial_in),
    .out(o1), .carry(c1), .zero(z1), .overflow(v1));

  register_universal_nbits #(.WIDTH(8), .STEP(1), .RESET_VALUE(8'd9)) u2 (
    .clock(clock), .clear(clear), .enable(enable), .mode(mode),
    .register_in(rin), .serial_in(serial_in),
    .out(o2), .carry(c2), .zero(z2), .overflow(v2));

  localparam logic [2:0] HOLD = 3'd0, LOAD = 3'd1, SHL = 3'd2, SHR = 3'd3,
                         ROL = 3'd4, ROR = 3'd5, INC = 3'd6, DEC = 3'd7;

  int checks = 0;
  int errors = 0;

  // Reference state per instance, held as plain integers.
  int m_out [3];
  int m_c   [3];
  int m_ov  [3];
  int mw    [3] = '{5, 5, 8};
  int ms    [3] = '{1, 3, 1};
  int mrv   [3] = '{0, 0, 9};

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_step(input int i);
    int m, h, t;
    m = 1 << mw[i];
    h = m / 2;
    if (clear) begin
      m_out[i] = mrv[i]; m_c[i] = 0; m_ov[i] = 0;
    end else if (enable && !$isunknown(mode)) begin
      case (mode)
        LOAD: begin m_out[i] = int'(rin) % m; m_c[i] = 0; m_ov[i] = 0; end
        SHL:  begin m_c[i] = m_out[i] / h; m_out[i] = (m_out[i] * 2 + int'(serial_in)) % m; end
        SHR:  begin m_c[i] = m_out[i] % 2; m_out[i] = m_out[i] / 2 + int'(serial_in) * h; end
        ROL:  begin m_c[i] = m_out[i] / h; m_out[i] = (m_out[i] * 2 + m_c[i]) % m; end
        ROR:  begin m_c[i] = m_out[i] % 2; m_out[i] = m_out[i] / 2 + m_c[i] * h; end
        INC: begin
          t = m_out[i] + ms[i];
          m_c[i] = (t >= m) ? 1 : 0;
          m_out[i] = t % m;
          if (m_c[i] == 1) m_ov[i] = 1;
        end
        DEC: begin
          m_c[i] = (m_out[i] < ms[i]) ? 1 : 0;
          m_out[i] = (m_out[i] - ms[i] + m) % m;
          if (m_c[i] == 1) m_ov[i] = 1;
        end
        default: ;
      endcase
    end
  endtask

  task automatic check_all();
    chk("u0_out", {27'd0, o0}, m_out[0]); chk("u0_carry", {31'd0, c0}, m_c[0]);
    chk("u0_zero", {31'd0, z0}, (m_out[0] == 0) ? 1 : 0); chk("u0_ovf", {31'd0, v0}, m_ov[0]);
    chk("u1_out", {27'd0, o1}, m_out[1]); chk("u1_carry", {31'd0, c1}, m_c[1]);
    chk("u1_zero", {31'd0, z1}, (m_out[1] == 0) ? 1 : 0); chk("u1_ovf", {31'd0, v1}, m_ov[1]);
    chk("u2_out", {24'd0, o2}, m_out[2]); chk("u2_carry", {31'd0, c2}, m_c[2]);
    chk("u2_zero", {31'd0, z2}, (m_out[2] == 0) ? 1 : 0); chk("u2_ovf", {31'd0, v2}, m_ov[2]);
  endtask

  task automatic cyc(input logic clr, input logic en, input logic [2:0] md,
                     input logic [7:0] d, input logic si);
    clear = clr; enable = en; mode = md; rin = d; serial_in = si;
    @(posedge clock);
    for (int i = 0; i < 3; i++) model_step(i);
    #1;
    check_all();
  endtask

  initial begin
    for (int i = 0; i < 3; i++) begin m_out[i] = 0; m_c[i] = 0; m_ov[i] = 0; end
    clear = 1'b0; enable = 1'b0; mode = HOLD; rin = '0; serial_in = 1'b0;
    @(negedge clock);

    // 1: reset, load, enable gating
    cyc(1, 0, HOLD, 8'd0, 0);
    chk("t1_rst_out", {27'd0, o0}, 0); chk("t1_rst_zero", {31'd0, z0}, 1);
    chk("t1_rst_u2_out", {24'd0, o2}, 9); chk("t1_rst_u2_zero", {31'd0, z2}, 0);
    cyc(0, 1, LOAD, 8'd3, 0);
    chk("t1_load_out", {27'd0, o0}, 3); chk("t1_load_zero", {31'd0, z0}, 0);
    cyc(0, 0, LOAD, 8'd10, 0);
    chk("t1_hold_out", {27'd0, o0}, 3);

    // 2: clear beats enable/load; clear with enable low
    cyc(1, 1, LOAD, 8'd33, 0);
    chk("t2_clr_out", {27'd0, o0}, 0); chk("t2_clr_ovf", {31'd0, v0}, 0);
    cyc(0, 1, LOAD, 8'd23, 0);
    cyc(1, 0, HOLD, 8'd0, 0);
    chk("t2_clr2_out", {27'd0, o0}, 0);

    // 3: INC wrap, sticky overflow, LOAD clears it
    cyc(0, 1, LOAD, 8'd31, 0);
    cyc(0, 1, INC, 8'd0, 0);
    chk("t3_wrap_out", {27'd0, o0}, 0); chk("t3_wrap_c", {31'd0, c0}, 1);
    chk("t3_wrap_z", {31'd0, z0}, 1); chk("t3_wrap_v", {31'd0, v0}, 1);
    cyc(0, 1, INC, 8'd0, 0);
    chk("t3_inc_out", {27'd0, o0}, 1); chk("t3_inc_c", {31'd0, c0}, 0);
    chk("t3_sticky_v", {31'd0, v0}, 1);
    cyc(0, 1, SHL, 8'd0, 1);
    chk("t3_shift_keeps_v", {31'd0, v0}, 1);
    cyc(0, 1, LOAD, 8'd5, 0);
    chk("t3_load_clr_v", {31'd0, v0}, 0);

    // 4: DEC borrow; STEP=3 instance
    cyc(0, 1, LOAD, 8'd0, 0);
    cyc(0, 1, DEC, 8'd0, 0);
    chk("t4_dec_out", {27'd0, o0}, 31); chk("t4_dec_c", {31'd0, c0}, 1);
    chk("t4_dec_v", {31'd0, v0}, 1);
    cyc(0, 1, LOAD, 8'd4, 0);
    cyc(0, 1, DEC, 8'd0, 0);
    chk("t4_s3_out", {27'd0, o1}, 1); chk("t4_s3_c", {31'd0, c1}, 0);

    // 5: shifts and rotates
    cyc(0, 1, LOAD, 8'b10011, 0);
    cyc(0, 1, SHL, 8'd0, 1);
    chk("t5_shl", {27'd0, o0}, 5'b00111); chk("t5_shl_c", {31'd0, c0}, 1);
    cyc(0, 1, SHR, 8'd0, 0);
    chk("t5_shr", {27'd0, o0}, 5'b00011); chk("t5_shr_c", {31'd0, c0}, 1);
    cyc(0, 1, ROR, 8'd0, 0);
    chk("t5_ror", {27'd0, o0}, 5'b10001); chk("t5_ror_c", {31'd0, c0}, 1);
    cyc(0, 1, ROL, 8'd0, 0);
    chk("t5_rol", {27'd0, o0}, 5'b00011); chk("t5_rol_c", {31'd0, c0}, 1);
    cyc(0, 1, 3'bxxx, 8'd0, 0);
    chk("t5_xmode_hold", {27'd0, o0}, 5'b00011);

    // 6: 8-bit instance counts from RESET_VALUE to wrap
    cyc(1, 0, HOLD, 8'd0, 0);
    chk("t6_rst", {24'd0, o2}, 9);
    for (int k = 0; k < 246; k++) cyc(0, 1, INC, 8'd0, 0);
    chk("t6_top", {24'd0, o2}, 255); chk("t6_top_v", {31'd0, v2}, 0);
    cyc(0, 1, INC, 8'd0, 0);
    chk("t6_wrap", {24'd0, o2}, 0); chk("t6_wrap_c", {31'd0, c2}, 1);
    chk("t6_wrap_v", {31'd0, v2}, 1);

    // Randomised traffic; clear kept rare so counting runs get long.
    for (int k = 0; k < 600; k++)
      cyc(($urandom_range(0, 31) == 0), ($urandom_range(0, 7) != 0),
          3'($urandom_range(0, 7)), 8'($urandom), 1'($urandom));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
